stereo_pixel_packer: RTL and testbench
======================================

STEREO_PIXEL_PACKER -- requirements
Module: stereo_pixel_packer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, 240, pixels per image row.
REQ-002 SHALL have parameter IMG_HEIGHT, 320, rows per image.
REQ-003 SHALL have parameter PIX_PER_WORD, 6, 8-bit pixels per BRAM word; equals BLOCK_SIZE.
REQ-004 SHALL have port clk_in  input  1  sole clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port frame_start_in  input  1  one-cycle pulse that starts or restarts a frame.
REQ-007 SHALL have port pixel_in  input  8  grayscale pixel, row-major order.
REQ-008 SHALL have port pixel_valid_in  input  1  pixel_in valid this cycle.
REQ-009 SHALL have port ready_out  output  1  block accepts a pixel this cycle.
REQ-010 SHALL have port bram_addr_out  output  $clog2(IMG_HEIGHT*IMG_WIDTH/PIX_PER_WORD)  image BRAM word address (14 bits at defaults).
REQ-011 SHALL have port bram_din_out  output  8*PIX_PER_WORD  packed word (48 bits at defaults).
REQ-012 SHALL have port bram_we_out  output  1  write strobe for image BRAM.
REQ-013 SHALL have port frame_done_out  output  1  one-cycle pulse; whole frame written; drives stereo new_frame_in.
REQ-014 SHALL have port error_out  output  1  sticky protocol-error flag (see REQ-032).

Function
REQ-015 SHALL implement FSM states IDLE, PACK, DONE.
REQ-016 IDLE: ready_out=0; pixel_valid_in ignored; frame_start_in moves to PACK and zeroes the pixel, word and address counters.
REQ-017 PACK: ready_out=1; a pixel is accepted when pixel_valid_in=1 and ready_out=1; throughput is one pixel per cycle; gaps are allowed.
REQ-018 Packing order SHALL place the first pixel of a word in bits [47:40] and the sixth in bits [7:0], i.e. pixel k occupies bits [8*(PIX_PER_WORD-k)-1 -: 8].
REQ-019 On acceptance of pixel PIX_PER_WORD-1 of a word, the next cycle SHALL assert bram_we_out=1 for exactly one cycle, with bram_din_out set to the full word and bram_addr_out set to the word address.
REQ-020 Word address SHALL equal row*(IMG_WIDTH/PIX_PER_WORD)+word_idx, produced as a counter incrementing by 1 per write from 0 to 12799 at defaults; no multiplier.
REQ-021 ready_out SHALL stay high during the write cycle; pixel acceptance is not stalled by writes.
REQ-022 After acceptance of the last pixel of the frame (row IMG_HEIGHT-1, column IMG_WIDTH-1), the FSM SHALL enter DONE, with ready_out=0 from the next cycle.
REQ-023 DONE SHALL last one cycle, coincident with the final write, and frame_done_out=1 the cycle after that write; the FSM then returns to IDLE.
REQ-024 frame_start_in in PACK SHALL restart the frame: discard the partial word, produce no write, reset counters to 0, and remain in PACK; a pixel valid in the same cycle is discarded.
REQ-025 frame_start_in and pixel_valid_in in the same cycle in IDLE SHALL not accept the pixel; acceptance begins next cycle.
REQ-026 frame_start_in in DONE SHALL be ignored.
REQ-027 bram_addr_out and bram_din_out SHALL hold their last value when bram_we_out=0.
REQ-028 IMG_WIDTH not divisible by PIX_PER_WORD is unsupported; behaviour for it is undefined.

Reset
REQ-029 rst_in=1 SHALL force IDLE and set ready_out, bram_we_out, frame_done_out and error_out to 0, and bram_addr_out and bram_din_out to 0, on the next edge.
REQ-030 Reset mid-frame SHALL abandon the frame: no write of a partial word, no frame_done_out.
REQ-031 rst_in SHALL take priority over frame_start_in and pixel_valid_in.

Configuration
REQ-032 Macro PACKER_CHECK_EN defined: error_out SHALL set and stay at 1 until reset on frame_start_in in PACK with a nonzero pixel count, or on pixel_valid_in=1 while in DONE.
REQ-033 Macro PACKER_CHECK_EN undefined: error_out SHALL be constant 0 and the check logic SHALL be absent.

Verification
REQ-034 Reset, frame_start_in, then 76800 back-to-back pixels with value n mod 256 -> addr 0 din 0x000102030405; addr 1 din 0x060708090A0B; last write addr 12799; frame_done_out one cycle after last write; exactly 12800 writes.
REQ-035 Same frame with pixel_valid_in low every 3rd cycle -> identical write contents and addresses; bram_we_out never high two cycles per word.
REQ-036 9 pixels then frame_start_in -> no write for pixels 6-8 beyond word 0 at addr 0; next write is addr 0 with the new pixels; error_out=1 only with PACKER_CHECK_EN.
REQ-037 rst_in for 1 cycle after 100 pixels -> all outputs 0 next cycle; no further writes or frame_done_out until a new frame_start_in.
REQ-038 pixel_valid_in=1 for 20 cycles in IDLE -> ready_out=0, no writes, error_out=0.

Source files
------------

// File: rtl/stereo_pixel_packer.sv
// ============================================================================
// stereo_pixel_packer: packs row-major 8-bit pixels into BRAM words + frame_done
// Optional protocol checker: PACKER_CHECK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module stereo_pixel_packer #(
  parameter int IMG_WIDTH    = 240,
  parameter int IMG_HEIGHT   = 320,
  parameter int PIX_PER_WORD = 6
) (
  input  logic                                                   clk_in,
  input  logic                                                   rst_in,
  input  logic                                                   frame_start_in,
  input  logic [7:0]                                             pixel_in,
  input  logic                                                   pixel_valid_in,
  output logic                                                   ready_out,
  output logic [$clog2(IMG_HEIGHT*IMG_WIDTH/PIX_PER_WORD)-1:0]   bram_addr_out,
  output logic [8*PIX_PER_WORD-1:0]                              bram_din_out,
  output logic                                                   bram_we_out,
  output logic                                                   frame_done_out,
  output logic                                                   error_out
);

  localparam int TOTAL_WORDS = IMG_HEIGHT * IMG_WIDTH / PIX_PER_WORD;
  localparam int ADDR_W      = $clog2(TOTAL_WORDS);
  localparam int WORD_W      = 8 * PIX_PER_WORD;
  localparam int PIX_W       = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_WORDS - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PIX_W-1:0]    pix_idx;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [WORD_W-1:0]   shreg;
  logic [WORD_W-1:0]   word_next;
  logic                restart;
  logic                start;
  logic                accept;
  logic                word_full;
  logic                frame_last;

  // A frame_start in PACK wins over a coincident pixel, which is dropped.
  always_comb begin
    restart    = (state == PACK) && frame_start_in;
    start      = ((state == IDLE) && frame_start_in) || restart;
    accept     = (state == PACK) && pixel_valid_in && !frame_start_in;
    word_full  = accept && (pix_idx == LAST_PIX);
    frame_last = word_full && (addr_cnt == LAST_ADDR);
    word_next  = (shreg << 8) | WORD_W'(pixel_in);
    state_nxt  = state;
    case (state)
      IDLE:    if (frame_start_in) state_nxt = PACK;
      PACK:    if (frame_last)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready_out = (state == PACK);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      pix_idx        <= '0;
      addr_cnt       <= '0;
      shreg          <= '0;
      bram_we_out    <= 1'b0;
      bram_addr_out  <= '0;
      bram_din_out   <= '0;
      frame_done_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      bram_we_out    <= word_full;
      frame_done_out <= (state == DONE);
      if (start) begin
        pix_idx  <= '0;
        addr_cnt <= '0;
      end else if (accept) begin
        shreg <= word_next;
        if (word_full) begin
          pix_idx       <= '0;
          addr_cnt      <= addr_cnt + 1'b1;
          bram_addr_out <= addr_cnt;
          bram_din_out  <= word_next;
        end else begin
          pix_idx <= pix_idx + 1'b1;
        end
      end
    end
  end

`ifdef PACKER_CHECK_EN
  logic error_q;

  // Sticky: restart of a partially received frame, or a pixel offered in DONE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      error_q <= 1'b0;
    end else if ((restart && ((addr_cnt != '0) || (pix_idx != '0))) ||
                 ((state == DONE) && pixel_valid_in)) begin
      error_q <= 1'b1;
    end
  end

  assign error_out = error_q;
`else
  assign error_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stereo_pixel_packer.sv
// ============================================================================
// tb_stereo_pixel_packer: directed self-checking bench for stereo_pixel_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stereo_pixel_packer;

  localparam int W     = 12;
  localparam int H     = 10;
  localparam int P     = 6;
  localparam int WORDS = W * H / P;
  localparam int AW    = $clog2(WORDS);
  localparam int DW    = 8 * P;
  localparam int NPIX  = W * H;

`ifdef PACKER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [7:0]    pixel = 8'd0;
  logic          ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          we;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_n  = 0;
  int done_n = 0;
  int dbl_we = 0;
  int done_cyc = -1;
  logic prev_we = 1'b0;
  logic [AW-1:0] wr_addr [64];
  logic [DW-1:0] wr_din  [64];
  int            wr_cyc  [64];

  always #5 clk = ~clk;

  stereo_pixel_packer #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .PIX_PER_WORD(P)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .frame_start_in(frame_start),
    .pixel_in      (pixel),
    .pixel_valid_in(pixel_valid),
    .ready_out     (ready),
    .bram_addr_out (addr),
    .bram_din_out  (din),
    .bram_we_out   (we),
    .frame_done_out(done),
    .error_out     (err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = addr;
        wr_din[wr_n]  = din;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
      if (prev_we === 1'b1) dbl_we++;
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
    prev_we = we;
  end

  function automatic logic [DW-1:0] exp_word(input int w, input int base);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < P; k++) r = {r[DW-9:0], 8'((base + w * P + k) % 256)};
    return r;
  endfunction

  task automatic clear_mon();
    wr_n = 0; done_n = 0; dbl_we = 0; done_cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Returns 1 ns after the edge that accepted the last pixel.
  task automatic drive_pixels(input int count, input bit gap, input int base);
    int n = 0;
    int c = 0;
    while (n < count) begin
      if (gap && (c % 3 == 2)) begin
        pixel_valid = 1'b0;
      end else begin
        pixel_valid = 1'b1;
        pixel = 8'((base + n) % 256);
        n++;
      end
      c++;
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b expected 0", ready); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b expected 0", we); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b expected 0", err); end
    total++; if (addr !== '0) begin bad++; $display("FAIL reset_addr: got %0h expected 0", addr); end
    total++; if (din !== '0) begin bad++; $display("FAIL reset_din: got %0h expected 0", din); end
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic test_idle_valid();
    int ready_hi = 0;
    do_reset();
    pixel_valid = 1'b1;
    pixel = 8'hA5;
    repeat (20) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) ready_hi++;
    end
    pixel_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (ready_hi !== 0) begin bad++; $display("FAIL idle_ready: got %0d high cycles expected 0", ready_hi); end
    total++; if (wr_n !== 0) begin bad++; $display("FAIL idle_writes: got %0d expected 0", wr_n); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL idle_err: got %0b expected 0", err); end
    total++; if (done_n !== 0) begin bad++; $display("FAIL idle_done: got %0d expected 0", done_n); end
  endtask

  task automatic test_frame(input bit gap);
    do_reset();
    pulse_start();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL frame_ready_start gap=%0b: got %0b expected 1", gap, ready); end
    drive_pixels(NPIX, gap, 0);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL frame_ready_end gap=%0b: got %0b expected 0", gap, ready); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (wr_n !== WORDS) begin bad++; $display("FAIL frame_writes gap=%0b: got %0d expected %0d", gap, wr_n, WORDS); end
    for (int i = 0; i < WORDS && i < wr_n; i++) begin
      total++;
      if (wr_addr[i] !== AW'(i) || wr_din[i] !== exp_word(i, 0)) begin
        bad++;
        $display("FAIL frame_word%0d gap=%0b: got addr %0h din %0h expected addr %0h din %0h",
                 i, gap, wr_addr[i], wr_din[i], i, exp_word(i, 0));
      end
    end
    total++; if (wr_din[0] !== 48'h000102030405) begin bad++; $display("FAIL frame_din0 gap=%0b: got %0h expected 000102030405", gap, wr_din[0]); end
    total++; if (wr_din[1] !== 48'h060708090A0B) begin bad++; $display("FAIL frame_din1 gap=%0b: got %0h expected 060708090a0b", gap, wr_din[1]); end
    total++; if (wr_addr[WORDS-1] !== AW'(WORDS - 1)) begin bad++; $display("FAIL frame_last_addr gap=%0b: got %0h expected %0h", gap, wr_addr[WORDS-1], WORDS - 1); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL frame_done_count gap=%0b: got %0d expected 1", gap, done_n); end
    total++; if (done_cyc !== wr_cyc[WORDS-1] + 1) begin bad++; $display("FAIL frame_done_timing gap=%0b: got cycle %0d expected %0d", gap, done_cyc, wr_cyc[WORDS-1] + 1); end
    total++; if (dbl_we !== 0) begin bad++; $display("FAIL frame_double_we gap=%0b: got %0d expected 0", gap, dbl_we); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL frame_err gap=%0b: got %0b expected 0", gap, err); end
  endtask

  task automatic test_restart();
    do_reset();
    pulse_start();
    drive_pixels(9, 1'b0, 0);
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    pixel = 8'hEE;
    @(posedge clk); #1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL restart_ready: got %0b expected 1", ready); end
    drive_pixels(6, 1'b0, 16);
    repeat (3) @(posedge clk);
    #1;
    total++; if (wr_n !== 2) begin bad++; $display("FAIL restart_writes: got %0d expected 2", wr_n); end
    total++; if (wr_addr[0] !== '0 || wr_din[0] !== 48'h000102030405) begin bad++; $display("FAIL restart_word0: got addr %0h din %0h expected addr 0 din 000102030405", wr_addr[0], wr_din[0]); end
    total++; if (wr_addr[1] !== '0 || wr_din[1] !== 48'h101112131415) begin bad++; $display("FAIL restart_word1: got addr %0h din %0h expected addr 0 din 101112131415", wr_addr[1], wr_din[1]); end
    total++; if (err !== EXP_ERR) begin bad++; $display("FAIL restart_err: got %0b expected %0b", err, EXP_ERR); end
  endtask

  task automatic test_reset_mid();
    int n_before;
    do_reset();
    pulse_start();
    drive_pixels(100, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %0b expected 0", ready); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL mid_we: got %0b expected 0", we); end
    total++; if (addr !== '0 || din !== '0) begin bad++; $display("FAIL mid_bus: got addr %0h din %0h expected 0 0", addr, din); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL mid_flags: got done %0b err %0b expected 0 0", done, err); end
    n_before = wr_n;
    total++; if (n_before !== 16) begin bad++; $display("FAIL mid_writes_before: got %0d expected 16", n_before); end
    pixel_valid = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    pixel_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (wr_n !== n_before || done_n !== 0) begin bad++; $display("FAIL mid_quiet: got writes %0d done %0d expected %0d 0", wr_n, done_n, n_before); end
    pulse_start();
    drive_pixels(6, 1'b0, 64);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (wr_n !== n_before + 1 || wr_addr[n_before] !== '0 || wr_din[n_before] !== 48'h404142434445) begin
      bad++;
      $display("FAIL mid_new_frame: got writes %0d addr %0h din %0h expected %0d 0 404142434445",
               wr_n, wr_addr[n_before], wr_din[n_before], n_before + 1);
    end
  endtask

  task automatic test_done_cycle();
    do_reset();
    pulse_start();
    drive_pixels(NPIX, 1'b0, 0);
    pixel_valid = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL done_start_ignored: got ready %0b expected 0", ready); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_pulse: got %0b expected 1", done); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (err !== EXP_ERR) begin bad++; $display("FAIL done_err: got %0b expected %0b", err, EXP_ERR); end
    total++; if (wr_n !== WORDS || done_n !== 1) begin bad++; $display("FAIL done_counts: got writes %0d done %0d expected %0d 1", wr_n, done_n, WORDS); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL done_idle_ready: got %0b expected 0", ready); end
  endtask

  initial begin
    test_reset();
    test_idle_valid();
    test_frame(1'b0);
    test_frame(1'b1);
    test_restart();
    test_reset_mid();
    test_done_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
